// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the RV32 opcodes the fetch-stage predictor understands.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PREDICT = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DRAIN   = 3'd5
    } fetch_state_e;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's icache, predictor, redirect and queue signals.
//
// Handshake semantics: every *Valid strobe is a single-cycle pulse and its
// payload is meaningful only in that cycle. There is no ready on the icache
// side; queueFull acts as the inverse of ready for the instruction queue, so
// outValid is only ever raised in a cycle where queueFull is low, and that
// cycle is the transfer.
interface fetch_unit_if;
    logic        icacheReqValid;
    logic [31:0] icacheAddr;
    logic        icacheRespValid;
    logic [31:0] icacheInstr;
    logic        predInstrValid;
    logic [31:0] predInstrAddr;
    logic        predJump;
    logic        flushValid;
    logic [31:0] flushPc;
    logic        queueFull;
    logic        outValid;
    logic [31:0] outInstr;
    logic [31:0] outPc;
    logic        outPredTaken;

    // The fetch unit side.
    modport master (
        output icacheReqValid, icacheAddr,
        input  icacheRespValid, icacheInstr,
        output predInstrValid, predInstrAddr,
        input  predJump,
        input  flushValid, flushPc,
        input  queueFull,
        output outValid, outInstr, outPc, outPredTaken
    );

    // The surrounding pipeline: icache, predictor, ROB and queue.
    modport slave (
        input  icacheReqValid, icacheAddr,
        output icacheRespValid, icacheInstr,
        input  predInstrValid, predInstrAddr,
        output predJump,
        output flushValid, flushPc,
        output queueFull,
        input  outValid, outInstr, outPc, outPredTaken
    );
endinterface

// File: rtl/fetch_decode.sv
// Next-pc decode for one fetched word: recognises JAL and conditional
// branches, everything else falls through to pc+4.
module fetch_decode
    import fetch_unit_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        pred_jump_i,
    output logic        taken_o,
    output logic [31:0] next_o
);

    logic [31:0] imm_j;
    logic [31:0] imm_b;

    // Sign-extended J and B immediates; additions below wrap modulo 2^32.
    always_comb begin
        imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    end

    // JALR targets depend on a register value, so they are never predicted.
    always_comb begin
        taken_o = 1'b0;
        next_o  = pc_i + 32'd4;
        case (instr_i[6:0])
            OPC_JAL: begin
                taken_o = 1'b1;
                next_o  = pc_i + imm_j;
            end
            OPC_BRANCH: begin
                taken_o = pred_jump_i;
                next_o  = pred_jump_i ? (pc_i + imm_b) : (pc_i + 32'd4);
            end
            OPC_JALR: begin
                taken_o = 1'b0;
                next_o  = pc_i + 32'd4;
            end
            default: begin
                taken_o = 1'b0;
                next_o  = pc_i + 32'd4;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word from the
// icache, asks the predictor about it, decodes the next pc and hands the word
// to the instruction queue. ROB redirects override everything.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clockIn,
    input  logic         resetIn,
    fetch_unit_if.master bus,
    output fetch_state_e state_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         taken_q;
    logic [31:0]  target_q;

    logic         dec_taken;
    logic [31:0]  next_pc_d;

    fetch_decode u_decode (
        .instr_i     (instr_q),
        .pc_i        (pc_q),
        .pred_jump_i (bus.predJump),
        .taken_o     (dec_taken),
        .next_o      (next_pc_d)
    );

    assign state_o = state_q;

    // Fetch FSM plus pc / instruction / held-prediction registers.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.flushValid) pc_q <= bus.flushPc;
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    // The request already left this cycle, so its response
                    // must be swallowed before fetching from the new pc.
                    if (bus.flushValid) begin
                        pc_q    <= bus.flushPc;
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.flushValid) begin
                        pc_q    <= bus.flushPc;
                        state_q <= bus.icacheRespValid ? ST_REQ : ST_DRAIN;
                    end else if (bus.icacheRespValid) begin
                        instr_q <= bus.icacheInstr;
                        state_q <= ST_PREDICT;
                    end
                end
                ST_PREDICT: begin
                    if (bus.flushValid) begin
                        pc_q    <= bus.flushPc;
                        state_q <= ST_REQ;
                    end else if (bus.queueFull) begin
                        // predJump is only valid now, so freeze the decision.
                        taken_q  <= dec_taken;
                        target_q <= next_pc_d;
                        state_q  <= ST_HOLD;
                    end else begin
                        pc_q    <= next_pc_d;
                        state_q <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (bus.flushValid) begin
                        pc_q    <= bus.flushPc;
                        state_q <= ST_REQ;
                    end else if (!bus.queueFull) begin
                        pc_q    <= target_q;
                        state_q <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // A flush landing together with the awaited response
                    // consumes that response; staying in DRAIN would wait
                    // forever for a response that never comes.
                    if (bus.flushValid) begin
                        pc_q <= bus.flushPc;
                        if (bus.icacheRespValid) state_q <= ST_REQ;
                    end else if (bus.icacheRespValid) begin
                        state_q <= ST_REQ;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output strobes: payloads are zero whenever their strobe is low.
    always_comb begin
        bus.icacheReqValid = 1'b0;
        bus.icacheAddr     = '0;
        bus.predInstrValid = 1'b0;
        bus.predInstrAddr  = '0;
        bus.outValid       = 1'b0;
        bus.outInstr       = '0;
        bus.outPc          = '0;
        bus.outPredTaken   = 1'b0;
        case (state_q)
            ST_REQ: begin
                bus.icacheReqValid = 1'b1;
                bus.icacheAddr     = pc_q;
            end
            ST_WAIT: begin
                if (bus.icacheRespValid && !bus.flushValid) begin
                    bus.predInstrValid = 1'b1;
                    bus.predInstrAddr  = pc_q;
                end
            end
            ST_PREDICT: begin
                if (!bus.queueFull && !bus.flushValid) begin
                    bus.outValid     = 1'b1;
                    bus.outInstr     = instr_q;
                    bus.outPc        = pc_q;
                    bus.outPredTaken = dec_taken;
                end
            end
            ST_HOLD: begin
                if (!bus.queueFull && !bus.flushValid) begin
                    bus.outValid     = 1'b1;
                    bus.outInstr     = instr_q;
                    bus.outPc        = pc_q;
                    bus.outPredTaken = taken_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level reference model driving icache,
// predictor, redirect and queue; deliveries checked by a separate monitor.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_state_e dbg_state;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clockIn (clk),
        .resetIn (rst_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int deliveries = 0;

    logic [64:0] exp_q[$];            // {taken, pc, instr}
    logic [31:0] mem[logic [31:0]];   // icache contents
    logic [31:0] req_log[$];
    int          req_cyc_log[$];

    // reference model state (transaction level)
    logic [31:0] model_pc;
    bit          outstanding, dropped, decode_pending;
    logic [31:0] out_addr, dec_instr, dec_pc;
    int          cd;
    bit          last_req_seen;
    int          last_req_cycle;
    bit          stall_reported;

    // stimulus knobs
    int          dmin = 1, dmax = 1, qf_pct = 0, flush_pct = 0;
    bit          force_flush;
    logic [31:0] force_flush_pc;
    int          force_pj = -1;
    bit          flush_in_wait, flush_on_resp;
    logic [31:0] knob_flush_pc = 32'h100;
    bit          qf_burst_arm, release_check, hold_seen, tput_mode;
    int          qf_left;
    int          flush_cycle;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_req(input string name, input int idx, input logic [31:0] exp);
        if (idx < req_log.size()) check(name, 65'(req_log[idx]), 65'(exp));
        else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: request %0d never issued, expected addr %h", name, idx, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_valids"}, 65'({bus.icacheReqValid, bus.predInstrValid, bus.outValid, bus.outPredTaken}), 65'(0));
        check({name, "_addrs"}, 65'({bus.icacheAddr, bus.predInstrAddr}), 65'(0));
        check({name, "_out"}, 65'({bus.outInstr, bus.outPc}), 65'(0));
    endtask

    // icache contents: lazily filled with a mix of NOPs, JAL, branches, JALR, junk
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] r;
        int k;
        if (!mem.exists(a)) begin
            r = $urandom();
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2, 3: mem[a] = 32'h0000_0013;
                4:          mem[a] = {r[31:7], 7'b1101111};
                5, 6:       mem[a] = {r[31:7], 7'b1100011};
                7:          mem[a] = {r[31:7], 7'b1100111};
                default:    mem[a] = r;
            endcase
        end
        return mem[a];
    endfunction

    // next-pc rules written as plain signed arithmetic
    task automatic ref_decode(input logic [31:0] instr, input logic [31:0] pc, input bit pj,
                              output bit taken, output logic [31:0] nxt);
        longint imm;
        taken = 1'b0;
        nxt   = 32'(longint'(pc) + 4);
        if (instr[6:0] == 7'b1101111) begin
            imm = longint'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
            if (instr[31]) imm = imm - (longint'(1) << 21);
            taken = 1'b1;
            nxt   = 32'(longint'(pc) + imm);
        end else if (instr[6:0] == 7'b1100011) begin
            imm = longint'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
            if (instr[31]) imm = imm - (longint'(1) << 13);
            taken = pj;
            if (pj) nxt = 32'(longint'(pc) + imm);
        end
    endtask

    task automatic model_reset();
        model_pc       = RESET_PC;
        outstanding    = 0;
        dropped        = 0;
        decode_pending = 0;
        exp_q.delete();
        qf_left        = 0;
        release_check  = 0;
        last_req_seen  = 0;
        last_req_cycle = cycle;
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        bit          req_seen, resp, do_flush, qf, pj, exp_pv, tk, release_now;
        logic [31:0] fpc, nxt;
        @(posedge clk);
        #1;
        cycle++;
        resp = 0; exp_pv = 0; release_now = 0;
        req_seen = bus.icacheReqValid;
        if (req_seen) begin
            check("req_addr", 65'(bus.icacheAddr), 65'(model_pc));
            req_log.push_back(bus.icacheAddr);
            req_cyc_log.push_back(cycle);
            last_req_cycle = cycle;
            outstanding = 1;
            dropped     = 0;
            out_addr    = model_pc;
            cd          = $urandom_range(dmin, dmax);
        end else if (outstanding) begin
            cd--;
            if (cd <= 0) resp = 1;
        end

        do_flush = 0;
        fpc = $urandom();
        if (force_flush) begin
            do_flush = 1; fpc = force_flush_pc; force_flush = 0;
        end else if (flush_in_wait && outstanding && !dropped && !req_seen && !resp) begin
            do_flush = 1; fpc = knob_flush_pc; flush_in_wait = 0;
        end else if (flush_on_resp && resp && !dropped) begin
            do_flush = 1; fpc = knob_flush_pc; flush_on_resp = 0;
        end else if ($urandom_range(0, 99) < flush_pct) begin
            do_flush = 1;
        end
        if (do_flush) flush_cycle = cycle;

        if (qf_burst_arm && decode_pending && !do_flush) begin
            qf_left = 4; qf_burst_arm = 0;
        end
        if (qf_left > 0) begin
            qf = 1; qf_left--;
            if (qf_left == 0) release_check = 1;
        end else if (release_check) begin
            qf = 0; release_now = 1; release_check = 0;
        end else begin
            qf = ($urandom_range(0, 99) < qf_pct);
        end
        pj = (force_pj >= 0) ? (force_pj != 0) : bit'($urandom_range(0, 1));

        bus.icacheRespValid = resp;
        bus.icacheInstr     = resp ? mem_rd(out_addr) : $urandom();
        bus.flushValid      = do_flush;
        bus.flushPc         = do_flush ? fpc : $urandom();
        bus.queueFull       = qf;
        bus.predJump        = pj;

        if (do_flush) begin
            model_pc = fpc;
            exp_q.delete();
            decode_pending = 0;
            if (outstanding) begin
                if (resp) outstanding = 0;
                else dropped = 1;
            end
        end else begin
            if (decode_pending) begin
                ref_decode(dec_instr, dec_pc, pj, tk, nxt);
                exp_q.push_back({tk, dec_pc, dec_instr});
                model_pc = nxt;
                decode_pending = 0;
            end
            if (resp) begin
                outstanding = 0;
                if (!dropped) begin
                    decode_pending = 1;
                    dec_instr = mem_rd(out_addr);
                    dec_pc    = out_addr;
                    exp_pv    = 1;
                end
                dropped = 0;
            end
        end
        last_req_seen = req_seen;

        #1;
        check("pred_strobe", 65'(bus.predInstrValid), 65'(exp_pv));
        if (exp_pv) check("pred_addr", 65'(bus.predInstrAddr), 65'(dec_pc));
        if (release_now) begin
            check("hold_release", 65'(bus.outValid), 65'(1));
            hold_seen = 1;
        end
        if (!stall_reported && (cycle - last_req_cycle) > 40) begin
            stall_reported = 1;
            n_tests++;
            n_fail++;
            $display("FAIL fetch_progress: no icache request for %0d cycles", cycle - last_req_cycle);
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        force_flush    = 1;
        force_flush_pc = pc;
        step();
        req_log.delete();
        req_cyc_log.delete();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [64:0] e;
        int          last_out;
        bit          have_last;
        have_last = 0;
        last_out  = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.outValid === 1'b1) begin
                check("qf_gate", 65'(bus.queueFull), 65'(0));
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_unexpected: got outPc %h instr %h, none expected", bus.outPc, bus.outInstr);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {bus.outPredTaken, bus.outPc, bus.outInstr}, e);
                    deliveries++;
                end
                if (tput_mode) begin
                    if (have_last) check("out_spacing", 65'(cycle - last_out), 65'(3));
                    have_last = 1;
                    last_out  = cycle;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        rst_n = 1'b0;
        bus.icacheRespValid = 0; bus.icacheInstr = '0; bus.predJump = 0;
        bus.flushValid = 0; bus.flushPc = '0; bus.queueFull = 0;
        model_reset();
        for (int i = 0; i < 64; i++) mem[32'(i * 4)] = 32'h0000_0013;
        mem[32'h10] = 32'h0080_006F;   // jal +8
        mem[32'h20] = 32'hFE00_0EE3;   // beq x0,x0,-4

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        check("reset_state", 65'(dbg_state), 65'(ST_IDLE));

        // Back-to-back NOPs, one-cycle icache latency
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req_log.delete();
        tput_mode = 1;
        repeat (12) step();
        tput_mode = 0;
        check_req("seq_pc0", 0, 32'h0);
        check_req("seq_pc1", 1, 32'h4);
        check_req("seq_pc2", 2, 32'h8);

        // JAL +8 at 0x10
        redirect(32'h10);
        repeat (15) step();
        check_req("jal_fetch", 0, 32'h10);
        check_req("jal_target", 1, 32'h18);

        // Branch -4 at 0x20, predicted taken then not taken
        force_pj = 1;
        redirect(32'h20);
        repeat (15) step();
        check_req("br_taken", 1, 32'h1C);
        force_pj = 0;
        redirect(32'h20);
        repeat (15) step();
        check_req("br_not_taken", 1, 32'h24);
        force_pj = -1;

        // Queue full for 4 cycles starting in PREDICT
        hold_seen = 0;
        redirect(32'h40);
        qf_burst_arm = 1;
        repeat (15) step();
        check("hold_release_seen", 65'(hold_seen), 65'(1));

        // Flush in WAIT, response arriving two cycles later
        dmin = 3; dmax = 3;
        flush_in_wait = 1;
        guard = 0;
        while (flush_in_wait && guard < 20) begin step(); guard++; end
        req_log.delete();
        req_cyc_log.delete();
        repeat (20) step();
        check_req("flush_wait_addr", 0, 32'h100);

        // Flush coincident with the icache response
        flush_on_resp = 1;
        guard = 0;
        while (flush_on_resp && guard < 20) begin step(); guard++; end
        req_log.delete();
        req_cyc_log.delete();
        repeat (10) step();
        check_req("flush_resp_addr", 0, 32'h100);
        if (req_cyc_log.size() > 0) check("flush_resp_latency", 65'(req_cyc_log[0]), 65'(flush_cycle + 1));
        else check_req("flush_resp_latency", 0, 32'h100);

        // Asynchronous reset while waiting on the icache
        guard = 0;
        do begin step(); guard++; end
        while (!(outstanding && !dropped && cd > 0 && !last_req_seen) && guard < 20);
        #1;
        rst_n = 1'b0;
        bus.icacheRespValid = 1'b1;
        bus.icacheInstr     = 32'hDEAD_BEEF;
        #1;
        check_zero("async_reset");
        check("async_reset_state", 65'(dbg_state), 65'(ST_IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dmin = 1; dmax = 1;
        model_reset();
        req_log.delete();
        repeat (10) step();
        check_req("post_reset_addr", 0, RESET_PC);

        // Randomized traffic
        dmin = 1; dmax = 4; qf_pct = 30; flush_pct = 3;
        repeat (2500) step();

        qf_pct = 0; flush_pct = 0;
        repeat (30) step();
        check("queue_drained", 65'(exp_q.size()), 65'(0));
        check("deliveries_made", 65'(deliveries > 100), 65'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
